// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared ctrl codes, FSM states and lane helpers for the load/store unit
package ls_pkg;

  localparam logic [2:0] LS_NONE = 3'b000;
  localparam logic [2:0] LS_B    = 3'b001;
  localparam logic [2:0] LS_H    = 3'b010;
  localparam logic [2:0] LS_W    = 3'b011;
  localparam logic [2:0] LS_BU   = 3'b100;
  localparam logic [2:0] LS_HU   = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERROR
  } ls_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_NONE
  } ls_size_t;

  function automatic ls_size_t ls_size(input logic [2:0] ctrl);
    case (ctrl)
      LS_B, LS_BU: ls_size = SZ_BYTE;
      LS_H, LS_HU: ls_size = SZ_HALF;
      LS_W:        ls_size = SZ_WORD;
      default:     ls_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic [3:0] ls_be(input ls_size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: ls_be = 4'b0001 << off;
      SZ_HALF: ls_be = 4'b0011 << {off[1], 1'b0};
      SZ_WORD: ls_be = 4'b1111;
      default: ls_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] ls_wdata(input ls_size_t size, input logic [31:0] w);
    case (size)
      SZ_BYTE: ls_wdata = {4{w[7:0]}};
      SZ_HALF: ls_wdata = {2{w[15:0]}};
      default: ls_wdata = w;
    endcase
  endfunction

endpackage

// File: rtl/ls_load_align.sv
// rtl/ls_load_align.sv - selects the addressed lane(s) of a read word and extends them
module ls_load_align
  import ls_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ctrl)
      LS_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   rdata = {24'h0, byte_sel};
      LS_H:    rdata = {{16{half_sel[15]}}, half_sel};
      LS_HU:   rdata = {16'h0, half_sel};
      default: rdata = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store engine with alignment check and timeout
module load_store_unit
  import ls_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            ctrl,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  ls_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_inc;
  logic [2:0]      ctrl_q;
  logic [1:0]      off_q;
  logic            is_load_q, is_store_q;
  ls_size_t        size;
  logic            noop, misaligned, store_sel;
  logic [31:0]     load_data;

  // Request decode happens on the raw inputs so the IDLE exit can be chosen in one cycle.
  always_comb begin
    size       = ls_size(ctrl);
    noop       = !(is_load ^ is_store) || (size == SZ_NONE) ||
                 (is_store && (ctrl == LS_BU || ctrl == LS_HU));
    misaligned = ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    store_sel  = (state == IDLE) ? is_store : is_store_q;
    cnt_inc    = cnt + 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (noop)            state_n = DONE;
          else if (misaligned) state_n = ERROR;
          else                 state_n = ACCESS;
        end
      end
      ACCESS: begin
        // An ack on the cycle the counter would expire still wins.
        if (mem_ack)                                state_n = DONE;
        else if (cnt_inc == CW'(TIMEOUT_CYCLES))    state_n = ERROR;
      end
      DONE:    state_n = IDLE;
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  ls_load_align u_align (
    .ctrl      (ctrl_q),
    .offset    (off_q),
    .mem_rdata (mem_rdata[31:0]),
    .rdata     (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrl_q     <= LS_NONE;
      off_q      <= 2'b00;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      state   <= state_n;
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      err     <= (state_n == ERROR);
      mem_req <= (state_n == ACCESS);
      mem_we  <= (state_n == ACCESS) && store_sel;

      if (state == IDLE && start) begin
        ctrl_q     <= ctrl;
        off_q      <= addr[1:0];
        is_load_q  <= is_load;
        is_store_q <= is_store;
        mem_addr   <= {addr[ADDR_WIDTH-1:2], 2'b00};
        mem_be     <= ls_be(size, addr[1:0]);
        mem_wdata  <= ls_wdata(size, wdata[31:0]);
      end

      if (state != ACCESS)  cnt <= '0;
      else if (!mem_ack)    cnt <= cnt_inc;

      if (state == ACCESS && mem_ack && is_load_q) rdata <= load_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import ls_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, is_load, is_store, mem_ack;
  logic [2:0]  ctrl;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
    .ctrl(ctrl), .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic l, input logic s, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] w);
    is_load = l; is_store = s; ctrl = c; addr = a; wdata = w;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  int  reqcnt;
  int  quiet;
  bit  seen;

  initial begin
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_ack = 1'b0;
    ctrl = LS_NONE; addr = '0; wdata = '0; mem_rdata = '0;
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done_err", {30'b0, done, err}, 0);
    check("rst_req_we", {30'b0, mem_req, mem_we}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_be", {28'b0, mem_be}, 0);
    check("rst_addr", mem_addr, 0);
    reset = 1'b0;
    tick();

    // lb at 0x103
    issue(1, 0, LS_B, 32'h103, 0);
    check("lb_req", {31'b0, mem_req}, 1);
    check("lb_busy", {31'b0, busy}, 1);
    check("lb_be", {28'b0, mem_be}, 32'h8);
    check("lb_addr", mem_addr, 32'h100);
    check("lb_we", {31'b0, mem_we}, 0);
    ack(32'h80ABCDEF);
    check("lb_done", {30'b0, done, err}, 2);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    check("lb_req_drop", {31'b0, mem_req}, 0);
    tick();
    check("lb_idle", {30'b0, busy, done}, 0);

    issue(1, 0, LS_BU, 32'h103, 0);
    ack(32'h80ABCDEF);
    check("lbu_rdata", rdata, 32'h00000080);
    tick();
    issue(1, 0, LS_HU, 32'h102, 0);
    check("lhu_be", {28'b0, mem_be}, 32'hC);
    ack(32'h80ABCDEF);
    check("lhu_rdata", rdata, 32'h000080AB);
    tick();

    issue(1, 0, LS_H, 32'h100, 0);
    ack(32'h1234F00D);
    check("lh_rdata", rdata, 32'hFFFFF00D);
    tick();
    issue(1, 0, LS_W, 32'h104, 0);
    check("lw_be", {28'b0, mem_be}, 32'hF);
    check("lw_addr", mem_addr, 32'h104);
    ack(32'hDEADBEEF);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    tick();

    // sh at 0x102: rdata must keep the last load result
    issue(0, 1, LS_H, 32'h102, 32'h1234BEEF);
    check("sh_addr", mem_addr, 32'h100);
    check("sh_we", {31'b0, mem_we}, 1);
    check("sh_be", {28'b0, mem_be}, 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    ack(32'h55555555);
    check("sh_done", {30'b0, done, err}, 2);
    check("sh_rdata_held", rdata, 32'hDEADBEEF);
    check("sh_we_drop", {31'b0, mem_we}, 0);
    tick();

    issue(0, 1, LS_B, 32'h101, 32'h0000005A);
    check("sb_be", {28'b0, mem_be}, 32'h2);
    check("sb_wdata", mem_wdata, 32'h5A5A5A5A);
    ack(32'h0);
    tick();

    // misaligned: err one cycle after start, no memory request
    issue(1, 0, LS_W, 32'h102, 0);
    check("lw_mis_err", {29'b0, err, done, mem_req}, 4);
    tick();
    check("lw_mis_idle", {29'b0, busy, err, mem_req}, 0);
    issue(0, 1, LS_H, 32'h101, 32'hFFFF);
    check("sh_mis_err", {29'b0, err, done, mem_req}, 4);
    tick();

    // no-ops: done next cycle, no request, rdata untouched
    issue(1, 0, LS_NONE, 32'h100, 0);
    check("noop_none", {29'b0, done, err, mem_req}, 4);
    tick();
    issue(0, 1, LS_BU, 32'h100, 0);
    check("noop_st_bu", {29'b0, done, err, mem_req}, 4);
    tick();
    issue(1, 1, LS_W, 32'h100, 0);
    check("noop_both", {29'b0, done, err, mem_req}, 4);
    tick();
    issue(1, 0, 3'b111, 32'h100, 0);
    check("noop_bad_ctrl", {29'b0, done, err, mem_req}, 4);
    check("noop_rdata", rdata, 32'hDEADBEEF);
    tick();

    // ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick(); tick();
    mem_ack = 1'b0;
    check("idle_ack", {29'b0, busy, done, mem_req}, 0);
    check("idle_ack_rdata", rdata, 32'hDEADBEEF);

    // timeout with a start issued while busy
    issue(1, 0, LS_W, 32'h200, 0);
    reqcnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (mem_req) reqcnt++;
      if (err) seen = 1;
      if (i == 3) begin start = 1'b1; addr = 32'h300; end
      else start = 1'b0;
      if (!seen) tick();
    end
    start = 1'b0;
    check("to_req_cycles", reqcnt, 16);
    check("to_err_seen", {31'b0, seen}, 1);
    check("to_addr_kept", mem_addr, 32'h200);
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req || busy) quiet++;
    end
    check("to_not_queued", quiet, 0);

    // ack exactly at the timeout limit succeeds
    issue(1, 0, LS_W, 32'h500, 0);
    for (int i = 1; i < 16; i++) tick();
    check("lim_req", {31'b0, mem_req}, 1);
    ack(32'hCAFEF00D);
    check("lim_done", {30'b0, done, err}, 2);
    check("lim_rdata", rdata, 32'hCAFEF00D);
    tick();

    // reset in the third ACCESS cycle
    issue(1, 0, LS_W, 32'h400, 0);
    tick(); tick();
    check("rsta_req", {31'b0, mem_req}, 1);
    reset = 1'b1;
    tick();
    check("rsta_state", {28'b0, mem_req, busy, done, err}, 0);
    reset = 1'b0;
    tick();
    check("rsta_after", {28'b0, mem_req, busy, done, err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
